mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single synchronous memory block between the CPU step sequencer (port A) and a peripheral/DMA master (port B, e.g. a UART transmit buffer filler). Port A normally has priority. A starvation counter guarantees port B forward progress. Port B may claim short locked bursts. The arbiter sits between both masters and the memory block's address/write port, and routes the one-cycle-latency read data back to the owner.

## Interface
Parameters:
- ADDR_WIDTH, 16, requester address width; the low bits drive the memory block.
- DATA_WIDTH, 16, data word width.
- STARVE_LIMIT, 4, number of consecutive denied B cycles before B is forced a grant; legal range 1..255.
- MAX_BURST, 8, maximum B grants per locked burst; legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_req  input  1  port A requests memory this cycle.
- a_we  input  1  port A write (1) or read (0).
- a_addr  input  ADDR_WIDTH  port A address.
- a_wdata  input  DATA_WIDTH  port A write data.
- a_gnt  output  1  port A access accepted this cycle.
- a_rvalid  output  1  mem_rdata belongs to port A's read granted in the previous cycle.
- b_req, b_we, b_addr, b_wdata  inputs  same widths as port A  port B request.
- b_burst  input  1  B requests a locked burst; sampled on a B grant.
- b_gnt  output  1  port B access accepted this cycle.
- b_rvalid  output  1  read data valid for port B.
- mem_addr  output  ADDR_WIDTH  to memory read/write address.
- mem_we  output  1  memory write enable.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after the address.
- a_rdata, b_rdata  output  DATA_WIDTH  both wired to mem_rdata; qualified by the respective rvalid.

## Operation
- At most one of a_gnt and b_gnt is high per cycle. The granted port's addr, we and wdata are muxed combinationally onto mem_*.
- With no grant: mem_we = 0 and mem_addr = a_addr (the CPU keeps read-ahead behaviour).
- FSM has two states, ARB and BURST.
- ARB state, default priority: A wins if a_req is high.
- ARB state, B wins if any of these holds:
  - b_req && !a_req;
  - b_req && starve_cnt == STARVE_LIMIT;
  - b_req && fair_b. fair_b is set for one cycle after a burst ends and A held priority.
- starve_cnt increments each cycle b_req && !b_gnt, saturating at STARVE_LIMIT. It clears on b_gnt or !b_req.
- Burst entry: a B grant in ARB with b_burst = 1 moves to BURST with burst_cnt = 1.
- BURST state: b_gnt = b_req, a_gnt = 0, and burst_cnt increments per B grant.
- Burst exit: the FSM returns to ARB after the cycle where any of these holds:
  - !b_req;
  - !b_burst;
  - burst_cnt == MAX_BURST. The grant in that cycle still completes.
- On burst exit, a_prio is set: the next ARB cycle gives A priority even when starve_cnt is saturated. a_prio clears after one ARB cycle.
- rvalid: owner and read flag are registered on every grant. x_rvalid is high for exactly the cycle after a granted read by x.
- Reset low, effective immediately (asynchronous):
  - FSM returns to ARB;
  - starve_cnt, burst_cnt, a_prio, fair_b and the rvalid registers clear;
  - a_gnt, b_gnt and mem_we are forced to 0.
  - An in-flight rvalid is dropped.

## Timing
- Grant is combinational, in the same cycle as req. A requester holds req/addr/we/wdata stable until it samples gnt high at a clock edge.
- Writes commit at the edge where gnt is high.
- Read latency: grant cycle N gives rdata/rvalid in cycle N+1. Back-to-back reads yield rvalid on consecutive cycles.
- Starvation bound: with a_req held high, a requesting B is granted no later than the (STARVE_LIMIT+1)-th cycle of its request.
- Burst bound: A waits at most MAX_BURST cycles once a burst starts.
- Outputs after reset release: gnt 0 until a req arrives, rvalid 0, mem_we 0.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding (ARB = 1'b0, BURST = 1'b1);
  - the owner encoding (OWNER_A = 1'b0, OWNER_B = 1'b1);
  - counter width helper constants.
- All registers use the existing `dff` module, with reset tied to the active-low input after inversion at the top.
- One sub-module is natural: `sat_counter` (enable, clear, limit, at_limit output), instantiated for starve_cnt and burst_cnt.

## Test plan
- Only A reads 0x0010 then 0x0011 back-to-back -> a_gnt both cycles; a_rvalid on cycles N+1 and N+2 with the memory contents; b_rvalid never asserts.
- Simultaneous a_req and b_req for 10 cycles, STARVE_LIMIT = 4 -> A granted cycles 0-3, B granted cycle 4, starve_cnt = 0 at cycle 5, A granted cycles 5-8, B granted cycle 9.
- B write 0xBEEF to 0x0100 while A idle -> b_gnt, mem_we = 1, mem_addr = 0x0100 in the same cycle; a later A read of 0x0100 returns 0xBEEF.
- B burst, b_burst held high, MAX_BURST = 8, a_req high -> 8 consecutive b_gnt; the next cycle a_gnt = 1 despite b_req high; FSM back in ARB.
- b_burst dropped after 3 grants -> burst ends after the third; A wins the next cycle.
- Reset low mid-burst, the cycle after a B read grant -> b_rvalid = 0, both gnt = 0, mem_we = 0 immediately. After release: FSM in ARB, counters 0, and A wins the first contested cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter.
//                Contains the arbiter state encoding, the read-owner encoding
//                and the width of the starvation and burst counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Which port owns the read data returning next cycle
   typedef enum logic {
      OWNER_A = 1'b0,
      OWNER_B = 1'b1
   } owner_e;

   // Both counters have to hold limits up to 255
   localparam int C_CNT_W   = 8;
   localparam int C_CNT_MAX = (1 << C_CNT_W) - 1;

   // Clamp an integer limit into the counter width
   function automatic logic [C_CNT_W-1:0] to_cnt(input int unsigned val);
      int unsigned clamped;
      clamped = (val > C_CNT_MAX) ? C_CNT_MAX : val;
      return clamped[C_CNT_W-1:0];
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
//  Module      : dff
//  Description : Generic register with asynchronous active-high reset.
//  Ports       : clk  - clock
//                rst  - asynchronous reset, active high
//                i_d  - next value
//                o_q  - registered value
//  Revision    : 1.0 - initial release
// ============================================================================
module dff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q <= RESET_VAL;
      end else begin
         o_q <= i_d;
      end
   end

endmodule : dff
`default_nettype wire

// File: rtl/mem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that saturates at a programmable limit.
//                Clear has priority over enable.
//  Ports       : clk        - clock
//                rst        - asynchronous reset, active high
//                i_en       - count up by one (held once at the limit)
//                i_clr      - return to zero
//                i_limit    - saturation value
//                o_at_limit - count equals the limit
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = C_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_limit,
   output logic             o_at_limit
);

   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_en && !o_at_limit) begin
         count_d = count_q + C_ONE;
      end
   end

   dff #(.WIDTH(WIDTH)) u_count_reg (
      .clk (clk),
      .rst (rst),
      .i_d (count_d),
      .o_q (count_q)
   );

   assign o_at_limit = (count_q == i_limit);

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one synchronous memory between the CPU (port A, normal
//                priority) and a DMA/peripheral master (port B). B gets a
//                forced grant after STARVE_LIMIT denied cycles and may hold
//                the memory for locked bursts of up to MAX_BURST grants.
//                Read data (one-cycle latency) is tagged back to its owner.
//  Ports       : clock, reset (async, active low)
//                a_req/a_we/a_addr/a_wdata -> a_gnt, a_rvalid, a_rdata
//                b_req/b_we/b_addr/b_wdata/b_burst -> b_gnt, b_rvalid, b_rdata
//                mem_addr/mem_we/mem_wdata -> memory, mem_rdata <- memory
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   // Port A (CPU)
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   // Port B (DMA / peripheral)
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   input  logic                  b_burst,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   // Memory side
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [C_CNT_W-1:0] C_STARVE_LIM = to_cnt(STARVE_LIMIT);
   // Burst counter holds grants already taken; the grant that makes
   // MAX_BURST is the one seen while the count sits at MAX_BURST-1.
   localparam logic [C_CNT_W-1:0] C_BURST_LAST = to_cnt(MAX_BURST - 1);
   // A single-grant burst never needs the BURST state
   localparam logic               C_BURST_EN   = (MAX_BURST > 1);

   logic       w_rst;
   logic       w_a_win;
   logic       w_b_win;
   logic       w_starve_at_limit;
   logic       w_burst_at_limit;
   logic       w_burst_en;
   logic       w_burst_clr;

   arb_state_e state_d;
   arb_state_e state_q;
   logic       state_bits_q;
   logic       a_prio_d;
   logic       a_prio_q;
   logic       fair_b_d;
   logic       fair_b_q;
   logic       rd_pend_d;
   logic       rd_pend_q;
   owner_e     owner_d;
   owner_e     owner_q;
   logic       owner_bits_q;

   assign w_rst = ~reset;

   // ------------------------------------------------------------------------
   // Arbitration and next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_a_win  = 1'b0;
      w_b_win  = 1'b0;
      state_d  = state_q;
      a_prio_d = a_prio_q;
      fair_b_d = 1'b0;
      case (state_q)
         ARB: begin
            // a_prio (first cycle after a burst) outranks both the
            // starvation override and the fairness turn.
            w_b_win  = b_req && (!a_req ||
                                 (!a_prio_q && (w_starve_at_limit || fair_b_q)));
            w_a_win  = a_req && !w_b_win;
            a_prio_d = 1'b0;
            // A used its post-burst priority; give B the following cycle
            fair_b_d = a_prio_q && w_a_win;
            if (w_b_win && b_burst && C_BURST_EN) begin
               state_d = BURST;
            end
         end
         BURST: begin
            w_b_win = b_req;
            if (!b_req || !b_burst || w_burst_at_limit) begin
               state_d  = ARB;
               a_prio_d = 1'b1;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   // Grants are killed the moment reset is asserted
   assign a_gnt = w_a_win & reset;
   assign b_gnt = w_b_win & reset;

   // ------------------------------------------------------------------------
   // Memory request mux; idle cycles keep presenting A's address
   // ------------------------------------------------------------------------
   always_comb begin
      mem_addr  = a_addr;
      mem_we    = 1'b0;
      mem_wdata = a_wdata;
      if (b_gnt) begin
         mem_addr  = b_addr;
         mem_we    = b_we;
         mem_wdata = b_wdata;
      end else if (a_gnt) begin
         mem_we    = a_we;
      end
   end

   // ------------------------------------------------------------------------
   // Read return tagging
   // ------------------------------------------------------------------------
   assign rd_pend_d = (a_gnt && !a_we) || (b_gnt && !b_we);
   assign owner_d   = b_gnt ? OWNER_B : (a_gnt ? OWNER_A : owner_q);

   assign a_rvalid  = rd_pend_q && (owner_q == OWNER_A);
   assign b_rvalid  = rd_pend_q && (owner_q == OWNER_B);
   assign a_rdata   = mem_rdata;
   assign b_rdata   = mem_rdata;

   // ------------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------------
   sat_counter #(.WIDTH(C_CNT_W)) u_starve_cnt (
      .clk        (clock),
      .rst        (w_rst),
      .i_en       (b_req && !b_gnt),
      .i_clr      (b_gnt || !b_req),
      .i_limit    (C_STARVE_LIM),
      .o_at_limit (w_starve_at_limit)
   );

   // Count grants while the burst continues; clear whenever ARB is next
   assign w_burst_en  = b_gnt && (state_d == BURST);
   assign w_burst_clr = (state_d == ARB);

   sat_counter #(.WIDTH(C_CNT_W)) u_burst_cnt (
      .clk        (clock),
      .rst        (w_rst),
      .i_en       (w_burst_en),
      .i_clr      (w_burst_clr),
      .i_limit    (C_BURST_LAST),
      .o_at_limit (w_burst_at_limit)
   );

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   dff #(.WIDTH(1)) u_state_reg (
      .clk (clock), .rst (w_rst), .i_d (state_d), .o_q (state_bits_q)
   );
   assign state_q = arb_state_e'(state_bits_q);

   dff #(.WIDTH(1)) u_a_prio_reg (
      .clk (clock), .rst (w_rst), .i_d (a_prio_d), .o_q (a_prio_q)
   );

   dff #(.WIDTH(1)) u_fair_b_reg (
      .clk (clock), .rst (w_rst), .i_d (fair_b_d), .o_q (fair_b_q)
   );

   dff #(.WIDTH(1)) u_rd_pend_reg (
      .clk (clock), .rst (w_rst), .i_d (rd_pend_d), .o_q (rd_pend_q)
   );

   dff #(.WIDTH(1)) u_owner_reg (
      .clk (clock), .rst (w_rst), .i_d (owner_d), .o_q (owner_bits_q)
   );
   assign owner_q = owner_e'(owner_bits_q);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a behavioural
//                arbitration model and a synchronous memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int ADDR_WIDTH   = 16;
   localparam int DATA_WIDTH   = 16;
   localparam int STARVE_LIMIT = 4;
   localparam int MAX_BURST    = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_burst = 1'b0;
   logic [15:0] a_addr = 16'h0, a_wdata = 16'h0, b_addr = 16'h0, b_wdata = 16'h0;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
   logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata;
   logic [15:0] mem_rdata;

   always #5 clock = ~clock;

   mem_arbiter #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .STARVE_LIMIT (STARVE_LIMIT),
      .MAX_BURST    (MAX_BURST)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_gnt     (a_gnt),
      .a_rvalid  (a_rvalid),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_burst   (b_burst),
      .b_gnt     (b_gnt),
      .b_rvalid  (b_rvalid),
      .b_rdata   (b_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Synchronous memory block, 1024 words, one-cycle read latency
   logic [15:0] tb_mem [0:1023];
   initial begin
      for (int i = 0; i < 1024; i++) tb_mem[i] = 16'(i * 37 + 4096);
      forever begin
         @(posedge clock);
         if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wdata;
         mem_rdata <= tb_mem[mem_addr[9:0]];
      end
   end

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   logic [15:0] ref_mem [0:1023];
   bit          m_in_burst;
   int          m_waited;
   int          m_burst_grants;
   bit          m_a_first;
   bit          m_b_turn;
   bit          exp_a_gnt, exp_b_gnt, exp_we, exp_rv_a, exp_rv_b;
   logic [15:0] exp_addr, exp_wdata, exp_rdata;
   int          compared   = 0;
   int          mismatched = 0;

   function automatic void model_reset();
      m_in_burst     = 1'b0;
      m_waited       = 0;
      m_burst_grants = 0;
      m_a_first      = 1'b0;
      m_b_turn       = 1'b0;
      exp_rv_a       = 1'b0;
      exp_rv_b       = 1'b0;
   endfunction

   // Who owns the memory this cycle, from the current inputs
   function automatic void model_eval();
      bit b_wins;
      if (m_in_burst) begin
         exp_b_gnt = b_req;
         exp_a_gnt = 1'b0;
      end else begin
         b_wins = b_req && (!a_req ||
                  (!m_a_first && (m_waited >= STARVE_LIMIT || m_b_turn)));
         exp_b_gnt = b_wins;
         exp_a_gnt = a_req && !b_wins;
      end
      if (exp_b_gnt) begin
         exp_addr = b_addr; exp_we = b_we; exp_wdata = b_wdata;
      end else begin
         exp_addr = a_addr; exp_we = exp_a_gnt && a_we; exp_wdata = a_wdata;
      end
   endfunction

   // Advance the model across a clock edge
   function automatic void model_commit();
      bit next_turn;
      next_turn = 1'b0;
      exp_rv_a  = exp_a_gnt && !a_we;
      exp_rv_b  = exp_b_gnt && !b_we;
      exp_rdata = ref_mem[exp_addr[9:0]];
      if (exp_we) ref_mem[exp_addr[9:0]] = exp_wdata;
      if (b_req && !exp_b_gnt)
         m_waited = (m_waited < STARVE_LIMIT) ? m_waited + 1 : STARVE_LIMIT;
      else
         m_waited = 0;
      if (m_in_burst) begin
         if (exp_b_gnt) m_burst_grants++;
         if (!b_req || !b_burst || m_burst_grants == MAX_BURST) begin
            m_in_burst = 1'b0;
            m_a_first  = 1'b1;
         end
      end else begin
         next_turn = m_a_first && exp_a_gnt;
         m_a_first = 1'b0;
         if (exp_b_gnt && b_burst && MAX_BURST > 1) begin
            m_in_burst     = 1'b1;
            m_burst_grants = 1;
         end
      end
      m_b_turn = next_turn;
   endfunction

   task automatic drive(input bit ar, input bit aw, input logic [15:0] aa,
                        input logic [15:0] ad, input bit br, input bit bw,
                        input logic [15:0] ba, input logic [15:0] bd, input bit bb);
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_burst = bb;
   endtask

   task automatic tick();
      model_commit();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
         @(negedge clock);
         model_eval();
         tick();
      end
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      drive(1'b1, 1'b1, 16'h1234, 16'hAAAA, 1'b1, 1'b1, 16'h0002, 16'h5555, 1'b1);
      @(posedge clock);
      #1;
      compared++;
      if ({a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_held: gnt_a,gnt_b,we,rv_a,rv_b=%b required 00000",
                  {a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid});
      end
      drive(1'b0, 1'b0, 16'h1234, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      model_eval();
      compared++;
      if ({a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_release: gnt_a,gnt_b,we,rv_a,rv_b=%b required 00000",
                  {a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid});
      end
      compared++;
      if (mem_addr !== 16'h1234) begin
         mismatched++;
         $display("FAIL idle_addr: mem_addr=%h required 1234", mem_addr);
      end
      tick();
   endtask

   task automatic test_a_back_to_back();
      for (int i = 0; i < 4; i++) begin
         if (i < 2) drive(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
         else       drive(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
         @(negedge clock);
         model_eval();
         compared++;
         if ({a_gnt, b_gnt} !== {i < 2, 1'b0}) begin
            mismatched++;
            $display("FAIL a_b2b_gnt cyc%0d: a,b=%b%b required %b0", i, a_gnt, b_gnt, i < 2);
         end
         compared++;
         if ({a_rvalid, b_rvalid} !== {i == 1 || i == 2, 1'b0}) begin
            mismatched++;
            $display("FAIL a_b2b_rvalid cyc%0d: a,b=%b%b required %b0", i, a_rvalid, b_rvalid,
                     i == 1 || i == 2);
         end
         if (i == 1 || i == 2) begin
            compared++;
            if (a_rdata !== exp_rdata) begin
               mismatched++;
               $display("FAIL a_b2b_rdata cyc%0d: %h required %h", i, a_rdata, exp_rdata);
            end
         end
         tick();
      end
   endtask

   task automatic test_b_write();
      drive(1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0);
      @(negedge clock);
      model_eval();
      compared++;
      if ({a_gnt, b_gnt, mem_we, mem_addr, mem_wdata} !== {3'b011, 16'h0100, 16'hBEEF}) begin
         mismatched++;
         $display("FAIL b_write: a,b,we=%b%b%b addr=%h wdata=%h required 011 0100 BEEF",
                  a_gnt, b_gnt, mem_we, mem_addr, mem_wdata);
      end
      tick();
      drive(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clock);
      model_eval();
      tick();
      drive(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clock);
      model_eval();
      compared++;
      if ({a_rvalid, a_rdata} !== {1'b1, 16'hBEEF}) begin
         mismatched++;
         $display("FAIL b_write_readback: rvalid=%b rdata=%h required 1 BEEF", a_rvalid, a_rdata);
      end
      tick();
   endtask

   task automatic test_starvation();
      logic [15:0] baddr;
      baddr = 16'h0080;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b0, baddr, 16'h0, 1'b0);
         @(negedge clock);
         model_eval();
         compared++;
         if ({a_gnt, b_gnt} !== {!(i == 4 || i == 9), i == 4 || i == 9}) begin
            mismatched++;
            $display("FAIL starve cyc%0d: a,b=%b%b required %b%b", i, a_gnt, b_gnt,
                     !(i == 4 || i == 9), i == 4 || i == 9);
         end
         if (exp_b_gnt) baddr++;
         tick();
      end
      idle(2);
   endtask

   task automatic test_burst_max();
      logic [15:0] baddr;
      baddr = 16'h0200;
      for (int i = 0; i < 10; i++) begin
         drive(i > 0, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, baddr, 16'h0, i < 8);
         @(negedge clock);
         model_eval();
         compared++;
         if ({a_gnt, b_gnt} !== {i == 8, i != 8}) begin
            mismatched++;
            $display("FAIL burst_max cyc%0d: a,b=%b%b required %b%b", i, a_gnt, b_gnt, i == 8, i != 8);
         end
         compared++;
         if (b_rvalid !== exp_rv_b) begin
            mismatched++;
            $display("FAIL burst_max_rvalid cyc%0d: %b required %b", i, b_rvalid, exp_rv_b);
         end
         if (exp_b_gnt) baddr++;
         tick();
      end
      idle(2);
   endtask

   task automatic test_burst_drop();
      logic [15:0] baddr;
      baddr = 16'h0280;
      for (int i = 0; i < 5; i++) begin
         drive(i > 0, 1'b0, 16'h0024, 16'h0, 1'b1, 1'b1, baddr, 16'(16'hC000 + i), i < 2);
         @(negedge clock);
         model_eval();
         compared++;
         if ({a_gnt, b_gnt} !== {i == 3, i != 3}) begin
            mismatched++;
            $display("FAIL burst_drop cyc%0d: a,b=%b%b required %b%b", i, a_gnt, b_gnt, i == 3, i != 3);
         end
         if (exp_b_gnt) baddr++;
         tick();
      end
      idle(2);
   endtask

   task automatic test_reset_mid_burst();
      drive(1'b0, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b1);
      @(negedge clock);
      model_eval();
      compared++;
      if (b_gnt !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_burst_entry: b_gnt=%b required 1", b_gnt);
      end
      tick();
      drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0301, 16'h0, 1'b1);
      @(negedge clock);
      model_eval();
      compared++;
      if ({a_gnt, b_gnt} !== 2'b01) begin
         mismatched++;
         $display("FAIL rst_burst_hold: a,b=%b%b required 01", a_gnt, b_gnt);
      end
      tick();
      drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b1, 16'h0302, 16'h5555, 1'b1);
      #1;
      compared++;
      if ({b_rvalid, b_gnt, mem_we} !== 3'b111) begin
         mismatched++;
         $display("FAIL rst_pre: rv_b,gnt_b,we=%b%b%b required 111", b_rvalid, b_gnt, mem_we);
      end
      reset = 1'b0;
      #1;
      compared++;
      if ({a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid} !== 5'b0) begin
         mismatched++;
         $display("FAIL rst_async: gnt_a,gnt_b,we,rv_a,rv_b=%b required 00000",
                  {a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid});
      end
      model_reset();
      @(posedge clock);
      #2;
      reset = 1'b1;
      drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0303, 16'h0, 1'b0);
      @(negedge clock);
      model_eval();
      compared++;
      if ({a_gnt, b_gnt, b_rvalid} !== 3'b100) begin
         mismatched++;
         $display("FAIL rst_after: gnt_a,gnt_b,rv_b=%b%b%b required 100", a_gnt, b_gnt, b_rvalid);
      end
      tick();
      idle(2);
   endtask

   task automatic test_random();
      bit a_p, b_p;
      a_p = 1'b0;
      b_p = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!a_p && $urandom_range(0, 99) < 55) begin
            a_p = 1'b1;
            a_we = 1'($urandom_range(0, 1));
            a_addr = 16'($urandom_range(0, 31));
            a_wdata = 16'($urandom);
         end
         if (!b_p && $urandom_range(0, 99) < 45) begin
            b_p = 1'b1;
            b_we = 1'($urandom_range(0, 1));
            b_addr = 16'($urandom_range(0, 31));
            b_wdata = 16'($urandom);
         end
         a_req = a_p;
         b_req = b_p;
         b_burst = ($urandom_range(0, 99) < 60);
         @(negedge clock);
         model_eval();
         compared++;
         if ({a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid} !==
             {exp_a_gnt, exp_b_gnt, exp_we, exp_rv_a, exp_rv_b}) begin
            mismatched++;
            $display("FAIL rand_ctrl cyc%0d: gnt_a,gnt_b,we,rv_a,rv_b=%b required %b", c,
                     {a_gnt, b_gnt, mem_we, a_rvalid, b_rvalid},
                     {exp_a_gnt, exp_b_gnt, exp_we, exp_rv_a, exp_rv_b});
         end
         compared++;
         if (mem_addr !== exp_addr) begin
            mismatched++;
            $display("FAIL rand_addr cyc%0d: %h required %h", c, mem_addr, exp_addr);
         end
         if (exp_we) begin
            compared++;
            if (mem_wdata !== exp_wdata) begin
               mismatched++;
               $display("FAIL rand_wdata cyc%0d: %h required %h", c, mem_wdata, exp_wdata);
            end
         end
         if (exp_rv_a || exp_rv_b) begin
            compared++;
            if ((exp_rv_a ? a_rdata : b_rdata) !== exp_rdata) begin
               mismatched++;
               $display("FAIL rand_rdata cyc%0d: %h required %h", c,
                        exp_rv_a ? a_rdata : b_rdata, exp_rdata);
            end
         end
         if (exp_a_gnt) a_p = 1'b0;
         if (exp_b_gnt) b_p = 1'b0;
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i * 37 + 4096);
      model_reset();
      exp_a_gnt = 1'b0;
      exp_b_gnt = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = 16'h0;
      exp_wdata = 16'h0;
      exp_rdata = 16'h0;
      test_reset();
      test_a_back_to_back();
      test_b_write();
      test_starvation();
      test_burst_max();
      test_burst_drop();
      test_reset_mid_burst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule : tb_mem_arbiter
`default_nettype wire
